// File: rtl/block_data_memory.sv
// Block-organised main memory behind the data cache: 64 blocks x 4 bytes.
// One access at a time; busywait stalls the initiator for LATENCY+1 cycles per access.
module block_data_memory #(
  parameter int unsigned LATENCY = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [7:0] CountInit = 8'(LATENCY - 1);

  state_e      state_q;
  logic [7:0]  count_q;
  logic [5:0]  addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [7:0]  mem [256];

  // Held low during reset even if a request is still asserted.
  assign busywait = reset & ((state_q == StBusy) | ((state_q == StIdle) & (read | write)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      count_q  <= 8'h00;
      addr_q   <= 6'h00;
      wdata_q  <= 32'h0;
      wr_q     <= 1'b0;
      readdata <= 32'h0;
      for (int i = 0; i < 256; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (read | write) begin
            addr_q  <= address;
            wdata_q <= writedata;
            wr_q    <= write;
            count_q <= CountInit;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (count_q != 8'h00) begin
            count_q <= count_q - 8'h01;
          end else begin
            if (wr_q) begin
              mem[{addr_q, 2'd0}] <= wdata_q[7:0];
              mem[{addr_q, 2'd1}] <= wdata_q[15:8];
              mem[{addr_q, 2'd2}] <= wdata_q[23:16];
              mem[{addr_q, 2'd3}] <= wdata_q[31:24];
            end else begin
              readdata <= {mem[{addr_q, 2'd3}], mem[{addr_q, 2'd2}],
                           mem[{addr_q, 2'd1}], mem[{addr_q, 2'd0}]};
            end
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: scoreboard of expected readdata per access,
// busy-length checks, async reset behaviour and LATENCY=1 back-to-back timing.
module tb_block_data_memory;

  logic        clock;
  logic        reset;
  logic        read, write;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;

  logic        read1;
  logic [5:0]  address1;
  logic [31:0] readdata1;
  logic        busywait1;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [64];
  logic [31:0] model_rd;
  logic [31:0] sb [$];

  block_data_memory #(.LATENCY(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait)
  );

  block_data_memory #(.LATENCY(1)) dut1 (
    .clock     (clock),
    .reset     (reset),
    .read      (read1),
    .write     (1'b0),
    .address   (address1),
    .writedata (32'h0),
    .readdata  (readdata1),
    .busywait  (busywait1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (model_mem[i]) model_mem[i] = 32'h0;
    model_rd = 32'h0;
  endtask

  // Starts just after a rising edge in IDLE; returns just after a rising edge back in IDLE.
  // chg>0 moves address/writedata to zero at the start of that cycle index.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [5:0] a,
                        input logic [31:0] d, input int chg);
    logic [31:0] exp;
    int cyc;
    bit done;
    if (wr) begin
      exp = model_rd;
      model_mem[a] = d;
    end else begin
      exp = model_mem[a];
      model_rd = exp;
    end
    sb.push_back(exp);
    read = rd; write = wr; address = a; writedata = d;
    cyc = 0; done = 0;
    while (!done && cyc < 60) begin
      @(negedge clock);
      if (busywait) begin
        cyc++;
        @(posedge clock); #1;
        if (cyc == chg) begin
          address = 6'h00;
          writedata = 32'h0;
        end
      end else begin
        done = 1;
      end
    end
    check32({tag, "_busy_cycles"}, 32'(cyc), 32'd6);
    check32({tag, "_readdata"}, readdata, sb.pop_front());
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
  endtask

  logic [5:0] bw_pattern;

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; address = 6'h00; writedata = 32'h0;
    read1 = 1'b0; address1 = 6'h00;
    model_reset();
    #3;
    check32("reset_busywait", 32'(busywait), 32'd0);
    check32("reset_readdata", readdata, 32'h0);
    #9 reset = 1'b1;
    @(posedge clock); #1;

    access("rd_after_reset", 1'b1, 1'b0, 6'h2A, 32'h0, -1);
    access("wr_2a", 1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, -1);
    access("rd_2a", 1'b1, 1'b0, 6'h2A, 32'h0, -1);
    check32("byte_168", 32'(dut.mem[168]), 32'hEF);
    check32("byte_171", 32'(dut.mem[171]), 32'hDE);
    access("rd_2a_addr_change", 1'b1, 1'b0, 6'h2A, 32'h0, 2);
    access("wr_03", 1'b0, 1'b1, 6'h03, 32'hCAFEF00D, -1);
    access("rd_03", 1'b1, 1'b0, 6'h03, 32'h0, -1);
    access("rdwr_01", 1'b1, 1'b1, 6'h01, 32'h12345678, -1);
    access("rd_01", 1'b1, 1'b0, 6'h01, 32'h0, -1);
    access("wr_10_data_change", 1'b0, 1'b1, 6'h10, 32'hA5A55A5A, 1);
    access("rd_10", 1'b1, 1'b0, 6'h10, 32'h0, -1);

    // Write to 6'h05, then reset asynchronously in BUSY cycle 3.
    read = 1'b0; write = 1'b1; address = 6'h05; writedata = 32'hFFFFFFFF;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check32("midwr_reset_busywait", 32'(busywait), 32'd0);
    check32("midwr_reset_readdata", readdata, 32'h0);
    write = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    access("rd_05_after_reset", 1'b1, 1'b0, 6'h05, 32'h0, -1);
    access("rd_2a_after_reset", 1'b1, 1'b0, 6'h2A, 32'h0, -1);

    // LATENCY=1 instance: request held through DONE re-accepts the next cycle.
    read1 = 1'b1; address1 = 6'h00;
    for (int i = 5; i >= 0; i--) begin
      @(negedge clock);
      bw_pattern[i] = busywait1;
      @(posedge clock); #1;
    end
    read1 = 1'b0;
    check32("b2b_busywait_pattern", 32'(bw_pattern), 32'(6'b110110));
    check32("b2b_readdata", readdata1, 32'h0);
    @(negedge clock);
    check32("b2b_idle_busywait", 32'(busywait1), 32'd0);

    check32("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
